// File: rtl/axi_defs.sv
// Shared AXI4-Lite definitions: response codes, default widths and a
// small helper to classify error responses.
package axi_defs;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_MAX_OUTST  = 4;

  // SLVERR and DECERR both count as errors; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinationally visible head word. Pointers
// carry one extra wrap bit so full and empty can be told apart.
// Push and pop in the same cycle are allowed, including when full.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      wr_q;
  logic [PW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Pointer update; only the pointers are reset, storage is not.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage write; when full with a concurrent pop the slot being
  // overwritten is the head, which is read before the edge.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[PW-1:0]] <= wdata_i;
  end

  assign head_o  = mem_q[rd_q[PW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);

endmodule

// File: rtl/axi4l_write_master.sv
// AXI4-Lite write master: buffers write commands in a FIFO, issues them
// on independent AW/W channels with a bounded number of outstanding
// writes, reports each B response and counts error responses.
module axi4l_write_master
  import axi_defs::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int MAX_OUTST  = DEF_MAX_OUTST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                rsp_valid,
  output logic [1:0]          rsp_resp,
  output logic [15:0]         err_count,
  output logic [3:0]          outstanding,
  output logic                idle
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CMD_W  = ADDR_W + DATA_W + STRB_W;

  logic [CMD_W-1:0]  push_word;
  logic [CMD_W-1:0]  head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              eligible;
  logic              show_head;
  logic              aw_hs;
  logic              w_hs;
  logic              b_hs;
  logic              b_counted;

  logic              aw_sent_q, aw_sent_d;
  logic              w_sent_q,  w_sent_d;
  logic [3:0]        outst_q,   outst_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_resp_q,  rsp_resp_d;
  logic [15:0]       err_q,       err_d;

  assign push_word = {cmd_addr, cmd_data, cmd_strb};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_word),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A partially issued head must finish even at the outstanding limit,
  // otherwise a valid already raised would have to drop.
  assign eligible  = !reset && !fifo_empty &&
                     ((outst_q < 4'(MAX_OUTST)) || aw_sent_q || w_sent_q);
  assign show_head = !reset && !fifo_empty;

  assign awvalid = eligible && !aw_sent_q;
  assign wvalid  = eligible && !w_sent_q;
  assign awaddr  = show_head ? head[CMD_W-1 -: ADDR_W] : '0;
  assign wdata   = show_head ? head[STRB_W +: DATA_W]  : '0;
  assign wstrb   = show_head ? head[STRB_W-1:0]        : '0;

  assign bready    = !reset;
  assign cmd_ready = !reset && (!fifo_full || pop);
  assign push      = cmd_valid && cmd_ready;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_resp    = rsp_resp_q;
  assign err_count   = err_q;
  assign outstanding = outst_q;
  assign idle        = fifo_empty && (outst_q == 4'd0);

  // Next-state: issue flags, pop, outstanding count and response capture.
  always_comb begin
    aw_hs     = awvalid && awready;
    w_hs      = wvalid && wready;
    pop       = eligible && (aw_hs || aw_sent_q) && (w_hs || w_sent_q);
    aw_sent_d = pop ? 1'b0 : (aw_sent_q || aw_hs);
    w_sent_d  = pop ? 1'b0 : (w_sent_q || w_hs);

    b_hs      = bvalid && bready;
    // A B with nothing in flight only produces the response pulse.
    b_counted = b_hs && (outst_q != 4'd0);

    outst_d = outst_q;
    case ({pop, b_counted})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase

    rsp_valid_d = b_hs;
    rsp_resp_d  = b_hs ? bresp : rsp_resp_q;

    err_d = err_q;
    if (b_counted && resp_is_err(bresp) && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
  end

  // State registers; reset discards any in-flight bookkeeping at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      aw_sent_q   <= 1'b0;
      w_sent_q    <= 1'b0;
      outst_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_resp_q  <= RESP_OKAY;
      err_q       <= 16'd0;
    end else begin
      aw_sent_q   <= aw_sent_d;
      w_sent_q    <= w_sent_d;
      outst_q     <= outst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_resp_q  <= rsp_resp_d;
      err_q       <= err_d;
    end
  end

endmodule
